// File: rtl/mux4_rr_arbiter.sv
// Four-input round-robin arbiter that feeds a single registered output channel.
// The arbiter can optionally keep the grant on one requester for a burst of transfers.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [1:0]       last, last_nxt;
  logic [3:0]       burst_cnt, cnt_nxt;
  logic             load_en;
  logic             scan_hit;
  logic [1:0]       scan_idx;
  logic             gnt;
  logic [1:0]       gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             burst_done;

  assign load_en    = !out_valid || out_ready;
  assign burst_done = ({1'b0, burst_cnt} + 5'd1) == 5'(MAX_BURST);

  // The scan walks from the farthest slot to the nearest, so the nearest valid requester after last wins.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    scan_hit = 1'b0;
    scan_idx = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (in_valid[idx]) begin
        scan_hit = 1'b1;
        scan_idx = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = burst_cnt;
    gnt       = 1'b0;
    gnt_idx   = last;
    if (rst_n && load_en) begin
      if (state == BURST && in_valid[last]) begin
        gnt     = 1'b1;
        gnt_idx = last;
        cnt_nxt = burst_cnt + 4'd1;
        if (burst_done) begin
          state_nxt = IDLE;
        end
      end else if (scan_hit) begin
        // A released burst falls through to here, so re-arbitration costs no bubble.
        gnt       = 1'b1;
        gnt_idx   = scan_idx;
        last_nxt  = scan_idx;
        cnt_nxt   = 4'd1;
        state_nxt = (MAX_BURST > 1) ? BURST : IDLE;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end
  end

  assign in_ready = gnt ? (4'b0001 << gnt_idx) : 4'b0000;

  // Only the granted input reaches the mux output, so X data on idle inputs never leaks.
  always_comb begin
    gnt_data = '0;
    case (gnt_idx)
      2'd0:    gnt_data = d0;
      2'd1:    gnt_data = d1;
      2'd2:    gnt_data = d2;
      default: gnt_data = d3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 2'd3;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      state     <= state_nxt;
      last      <= last_nxt;
      burst_cnt <= cnt_nxt;
      out_valid <= gnt;
      if (gnt) begin
        out_data <= gnt_data;
        out_sel  <= gnt_idx;
      end
    end
  end

endmodule
